// File: rtl/meas_pkg.sv
// Shared types and defaults for the measurement readout path (dual-slope
// controller and BCD converter).
package meas_pkg;

  localparam int COUNT_WIDTH_DEF     = 32;
  localparam int DIGITS_DEF          = 6;
  localparam int RANGE_SEL_WIDTH_DEF = 2;

  typedef logic [3:0] bcd_digit_t;
  localparam bcd_digit_t BCD_NINE = 4'd9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    HOLD = 2'd2
  } state_e;

endpackage

// File: rtl/bcd_add3.sv
// Per-digit double-dabble correction: digits of 5 or more get +3 before
// the shift so that doubling carries correctly into the next decade.
module bcd_add3
  import meas_pkg::*;
(
  input  bcd_digit_t i_digit,
  output bcd_digit_t o_digit
);

  assign o_digit = (i_digit >= 4'd5) ? bcd_digit_t'(i_digit + 4'd3) : i_digit;

endmodule

// File: rtl/meas_bcd_conv.sv
// Captures a finished integration count and converts it to packed BCD one bit
// per clock. Optional macro: MEAS_BCD_LEADING_ZERO_BLANK_EN (leading-zero mask).
//
// Handshake: valid_o stays high with stable result outputs until a cycle in
// which valid_o and ready_i are both high; the result transfers on that edge.
module meas_bcd_conv
  import meas_pkg::*;
#(
  parameter int COUNT_WIDTH     = COUNT_WIDTH_DEF,
  parameter int DIGITS          = DIGITS_DEF,
  parameter int RANGE_SEL_WIDTH = RANGE_SEL_WIDTH_DEF
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       data_ready_i,
  input  logic [COUNT_WIDTH-1:0]     count_i,
  input  logic                       sign_i,
  input  logic [RANGE_SEL_WIDTH-1:0] range_i,
  input  logic                       error_i,
  input  logic                       ready_i,
  output logic                       valid_o,
  output logic                       busy_o,
  output logic [4*DIGITS-1:0]        bcd_o,
  output logic                       sign_o,
  output logic [RANGE_SEL_WIDTH-1:0] range_o,
  output logic                       overflow_o,
  output logic                       error_o,
  output logic                       drop_o,
  output logic [DIGITS-1:0]          blank_o
);

  localparam int BW   = 4 * DIGITS;
  localparam int CNTW = $clog2(COUNT_WIDTH + 1);
  localparam logic [BW-1:0] NINES = {DIGITS{BCD_NINE}};

  state_e                     r_state, w_state_next;
  logic [COUNT_WIDTH-1:0]     r_shift, w_shift_next;
  logic [BW-1:0]              r_bcd, w_bcd_next;
  logic [CNTW-1:0]            r_cnt, w_cnt_next;
  logic                       r_ovf, w_ovf_next;
  logic                       r_sign, w_sign_next;
  logic [RANGE_SEL_WIDTH-1:0] r_range, w_range_next;
  logic                       r_err, w_err_next;
  logic                       r_drop, w_drop_next;

  logic [BW-1:0] w_corr, w_shifted, w_final;
  logic          w_carry, w_ovf_any, w_last, w_accept;

  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .i_digit(r_bcd[4*g +: 4]),
      .o_digit(w_corr[4*g +: 4])
    );
  end

  // One conversion step; a 1 leaving the top digit means the value cannot fit.
  assign w_shifted = {w_corr[BW-2:0], r_shift[COUNT_WIDTH-1]};
  assign w_carry   = w_corr[BW-1];
  assign w_ovf_any = r_ovf | w_carry;
  assign w_final   = w_ovf_any ? NINES : w_shifted;
  assign w_last    = (r_cnt == CNTW'(1));
  assign w_accept  = data_ready_i && ((r_state == IDLE) || ((r_state == HOLD) && ready_i));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= IDLE;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_shift_next = r_shift;
    w_bcd_next   = r_bcd;
    w_cnt_next   = r_cnt;
    w_ovf_next   = r_ovf;
    w_sign_next  = r_sign;
    w_range_next = r_range;
    w_err_next   = r_err;
    w_drop_next  = 1'b0;
    case (r_state)
      CONV: begin
        w_shift_next = r_shift << 1;
        w_bcd_next   = w_last ? w_final : w_shifted;
        w_ovf_next   = w_ovf_any;
        w_cnt_next   = r_cnt - CNTW'(1);
        w_drop_next  = data_ready_i;
        if (w_last) w_state_next = HOLD;
      end
      HOLD: begin
        if (ready_i) w_state_next = IDLE;
        else         w_drop_next  = data_ready_i;
      end
      default: ;
    endcase
    // New captures override the above, including back-to-back from HOLD.
    if (w_accept) begin
      w_sign_next  = sign_i;
      w_range_next = range_i;
      w_bcd_next   = '0;
      w_ovf_next   = 1'b0;
      w_err_next   = error_i;
      if (error_i) begin
        w_shift_next = '0;
        w_cnt_next   = '0;
        w_state_next = HOLD;
      end else begin
        w_shift_next = count_i;
        w_cnt_next   = CNTW'(COUNT_WIDTH);
        w_state_next = CONV;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_shift <= '0;
      r_bcd   <= '0;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
      r_sign  <= 1'b0;
      r_range <= '0;
      r_err   <= 1'b0;
      r_drop  <= 1'b0;
    end else begin
      r_shift <= w_shift_next;
      r_bcd   <= w_bcd_next;
      r_cnt   <= w_cnt_next;
      r_ovf   <= w_ovf_next;
      r_sign  <= w_sign_next;
      r_range <= w_range_next;
      r_err   <= w_err_next;
      r_drop  <= w_drop_next;
    end
  end

`ifdef MEAS_BCD_LEADING_ZERO_BLANK_EN
  logic [DIGITS-1:0] r_blank, w_blank_next, w_blank_calc;

  always_comb begin : blank_calc
    logic w_hz;
    w_hz         = 1'b1;
    w_blank_calc = '0;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      w_hz            = w_hz & (w_final[4*k +: 4] == 4'd0);
      w_blank_calc[k] = w_hz;
    end
    if (w_ovf_any) w_blank_calc = '0;
  end

  always_comb begin
    w_blank_next = r_blank;
    if (w_accept)                         w_blank_next = '0;
    else if ((r_state == CONV) && w_last) w_blank_next = w_blank_calc;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_blank <= '0;
    else         r_blank <= w_blank_next;
  end

  assign blank_o = r_blank;
`else
  assign blank_o = '0;
`endif

  assign valid_o    = (r_state == HOLD);
  assign busy_o     = (r_state == CONV);
  assign bcd_o      = r_bcd;
  assign sign_o     = r_sign;
  assign range_o    = r_range;
  assign overflow_o = r_ovf;
  assign error_o    = r_err;
  assign drop_o     = r_drop;

endmodule

// File: tb/tb_meas_bcd_conv.sv
// Scoreboarded bench for meas_bcd_conv: directed test-plan cases followed by
// randomized transactions checked against a decimal-arithmetic reference model.
module tb_meas_bcd_conv;

  localparam int CW = 32;
  localparam int DG = 6;
  localparam int RW = 2;

  typedef struct packed {
    logic [4*DG-1:0] bcd;
    logic            sign;
    logic [RW-1:0]   rng;
    logic            ovf;
    logic            err;
    logic [DG-1:0]   blank;
  } exp_t;

  logic            clk_i = 1'b0;
  logic            rst_ni = 1'b0;
  logic            data_ready_i = 1'b0;
  logic [CW-1:0]   count_i = '0;
  logic            sign_i = 1'b0;
  logic [RW-1:0]   range_i = '0;
  logic            error_i = 1'b0;
  logic            ready_i = 1'b0;
  logic            valid_o, busy_o, sign_o, overflow_o, error_o, drop_o;
  logic [4*DG-1:0] bcd_o;
  logic [RW-1:0]   range_o;
  logic [DG-1:0]   blank_o;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  meas_bcd_conv dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .data_ready_i(data_ready_i), .count_i(count_i),
    .sign_i(sign_i), .range_i(range_i), .error_i(error_i), .ready_i(ready_i),
    .valid_o(valid_o), .busy_o(busy_o), .bcd_o(bcd_o), .sign_o(sign_o),
    .range_o(range_o), .overflow_o(overflow_o), .error_o(error_o),
    .drop_o(drop_o), .blank_o(blank_o)
  );

  // ---------------- clock ----------------
  always #5 clk_i = ~clk_i;

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: plain decimal arithmetic on the count.
  function automatic exp_t model(input longint unsigned cnt, input logic s,
                                 input logic [RW-1:0] r, input logic e);
    exp_t m;
    longint unsigned lim, p;
    m = '0;
    m.sign = s;
    m.rng  = r;
    lim = 1;
    for (int d = 0; d < DG; d++) lim = lim * 10;
    if (e) begin
      m.err = 1'b1;
    end else if (cnt >= lim) begin
      m.ovf = 1'b1;
      for (int d = 0; d < DG; d++) m.bcd[4*d +: 4] = 4'd9;
    end else begin
      p = 1;
      for (int d = 0; d < DG; d++) begin
        m.bcd[4*d +: 4] = 4'((cnt / p) % 10);
        p = p * 10;
`ifdef MEAS_BCD_LEADING_ZERO_BLANK_EN
        if (d + 1 < DG) m.blank[d+1] = (cnt < p);
`endif
      end
    end
    return m;
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk_i) begin
    if (rst_ni && valid_o && ready_i) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result", 64'(bcd_o), 64'hDEAD);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("bcd",      64'(bcd_o),      64'(e.bcd));
        chk("sign",     64'(sign_o),     64'(e.sign));
        chk("range",    64'(range_o),    64'(e.rng));
        chk("overflow", 64'(overflow_o), 64'(e.ovf));
        chk("error",    64'(error_o),    64'(e.err));
        chk("blank",    64'(blank_o),    64'(e.blank));
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Drives a one-cycle data_ready pulse; returns just after the sampling edge.
  task automatic pulse(input logic [CW-1:0] c, input logic s, input logic [RW-1:0] r,
                       input logic e, input logic rdy, input bit accept);
    @(posedge clk_i); #1;
    count_i = c; sign_i = s; range_i = r; error_i = e;
    data_ready_i = 1'b1;
    ready_i = rdy;
    if (accept) exp_q.push_back(model(longint'(c), s, r, e));
    @(posedge clk_i); #1;
    data_ready_i = 1'b0;
    error_i = 1'b0;
    ready_i = 1'b0;
  endtask

  // Counts negedges from the sampling edge until valid_o; checks latency and busy.
  task automatic wait_valid(input string name, input int exp_lat, input logic exp_busy);
    int   lat;
    logic seen_busy;
    lat = 0;
    seen_busy = 1'b0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk_i);
      if (valid_o) begin lat = i; break; end
      seen_busy = seen_busy | busy_o;
    end
    chk({name, "_latency"}, 64'(lat), 64'(exp_lat));
    chk({name, "_busy_seen"}, 64'(seen_busy), 64'(exp_busy));
  endtask

  task automatic handshake_now();
    @(posedge clk_i); #1;
    ready_i = 1'b1;
    @(posedge clk_i); #1;
    ready_i = 1'b0;
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_valid"}, 64'(valid_o), 64'd0);
    chk({name, "_busy"},  64'(busy_o),  64'd0);
    chk({name, "_bcd"},   64'(bcd_o),   64'd0);
    chk({name, "_sign"},  64'(sign_o),  64'd0);
    chk({name, "_range"}, 64'(range_o), 64'd0);
    chk({name, "_ovf"},   64'(overflow_o), 64'd0);
    chk({name, "_err"},   64'(error_o), 64'd0);
    chk({name, "_drop"},  64'(drop_o),  64'd0);
    chk({name, "_blank"}, 64'(blank_o), 64'd0);
  endtask

  function automatic logic [CW-1:0] rand_count();
    case ($urandom_range(0, 4))
      0:       return CW'($urandom);
      1:       return CW'($urandom_range(0, 999));
      2:       return CW'($urandom_range(999990, 1000010));
      3:       return CW'($urandom_range(0, 999999));
      default: return '0;
    endcase
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) @(posedge clk_i);
    #1;
    chk_all_zero("reset");
    rst_ni = 1'b1;

    // Directed conversions, each drained immediately.
    pulse(32'd123456, 1'b1, 2'd2, 1'b0, 1'b0, 1'b1);
    wait_valid("conv_123456", CW + 1, 1'b1);
    handshake_now();
    pulse(32'd999999, 1'b0, 2'd1, 1'b0, 1'b0, 1'b1);
    wait_valid("conv_999999", CW + 1, 1'b1);
    handshake_now();
    pulse(32'd1000000, 1'b0, 2'd3, 1'b0, 1'b0, 1'b1);
    wait_valid("conv_1000000", CW + 1, 1'b1);
    handshake_now();
    pulse(32'd0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b1);
    wait_valid("conv_zero", CW + 1, 1'b1);
    handshake_now();
    pulse(32'd42, 1'b0, 2'd1, 1'b0, 1'b0, 1'b1);
    wait_valid("conv_42", CW + 1, 1'b1);
    handshake_now();

    // Error path: valid next cycle, never busy.
    pulse(32'd555, 1'b1, 2'd3, 1'b1, 1'b0, 1'b1);
    wait_valid("error_path", 1, 1'b0);
    handshake_now();

    // Backpressure with a dropped pulse, then back-to-back capture.
    pulse(32'd500, 1'b0, 2'd2, 1'b0, 1'b0, 1'b1);
    wait_valid("bp_500", CW + 1, 1'b1);
    repeat (4) @(posedge clk_i);
    pulse(32'd31415, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
    @(negedge clk_i);
    chk("drop_pulse", 64'(drop_o), 64'd1);
    @(negedge clk_i);
    chk("drop_clear", 64'(drop_o), 64'd0);
    chk("drop_valid_held", 64'(valid_o), 64'd1);
    chk("drop_bcd_held", 64'(bcd_o), 64'h000500);
    repeat (3) @(posedge clk_i);
    pulse(32'd77, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1);
    @(negedge clk_i);
    chk("b2b_busy", 64'(busy_o), 64'd1);
    chk("b2b_valid_low", 64'(valid_o), 64'd0);
    wait_valid("b2b_77", CW, 1'b1);
    handshake_now();

    // Reset mid-conversion discards the result.
    pulse(32'd4242, 1'b1, 2'd3, 1'b0, 1'b0, 1'b1);
    repeat (10) @(posedge clk_i);
    #1;
    rst_ni = 1'b0;
    #1;
    chk_all_zero("mid_reset");
    exp_q.delete();
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    pulse(32'd8080, 1'b0, 2'd1, 1'b0, 1'b0, 1'b1);
    wait_valid("after_reset", CW + 1, 1'b1);
    handshake_now();

    // Randomized transactions with holds, drops and back-to-back loads.
    for (int t = 0; t < 40; t++) begin
      logic e;
      logic from_hold;
      e = ($urandom_range(0, 7) == 0);
      from_hold = (t > 0) && valid_o && ($urandom_range(0, 1) == 1);
      if (!from_hold && valid_o) handshake_now();
      pulse(rand_count(), 1'($urandom), RW'($urandom), e, from_hold, 1'b1);
      if (from_hold && e) wait_valid("rand_b2b_err", 1, 1'b0);
      else if (e)         wait_valid("rand_err", 1, 1'b0);
      else if (from_hold) wait_valid("rand_b2b", CW + 1, 1'b1);
      else                wait_valid("rand", CW + 1, 1'b1);
      repeat ($urandom_range(0, 3)) @(posedge clk_i);
      if ($urandom_range(0, 3) == 0) begin
        pulse(rand_count(), 1'($urandom), RW'($urandom), 1'b0, 1'b0, 1'b0);
        @(negedge clk_i);
        chk("rand_drop", 64'(drop_o), 64'd1);
      end
    end

    // Drain.
    @(posedge clk_i); #1;
    ready_i = 1'b1;
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk_i);
    #1;
    ready_i = 1'b0;
    chk("drain_queue_empty", 64'(exp_q.size()), 64'd0);
    repeat (2) @(posedge clk_i);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
